// File: rtl/uart_frame_rx.sv
// uart_frame_rx: pops bytes from the UART RX FIFO and decodes frames of the
// form SYNC, LEN, LEN payload bytes, CHK. Payload goes out on a valid/ready
// stream. A status pulse is issued per frame or per error.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx #(
  parameter int                   DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'hA5,
  parameter int                   MAX_LEN        = 16,
  parameter int                   TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  err_length,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_fifo_read;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_frame_done;
  logic                  r_frame_ok;
  logic                  r_err_length;
  logic                  r_err_timeout;

  logic                  w_out_free;
  logic                  w_consume;
  logic                  w_len_bad;
  logic [DATA_WIDTH-1:0] w_sum_add;
  logic                  w_to_fire;

  // The output slot is free when empty or being accepted this cycle.
  assign w_out_free = !r_out_valid || out_ready;

  // r_fifo_read doubles as the post-pop wait flag. PAYLOAD and CHECK both
  // wait for the output slot so frame_done never precedes the last byte.
  assign w_consume = !fifo_empty && !r_fifo_read &&
                     (((r_state != ST_PAYLOAD) && (r_state != ST_CHECK)) || w_out_free);

  assign w_len_bad = (fifo_data == '0) || (fifo_data > DATA_WIDTH'(MAX_LEN));
  assign w_sum_add = r_sum + fifo_data;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_stall;

  // A back-pressured output byte is not the sender's fault, so don't count.
  assign w_to_stall = r_out_valid && !out_ready;
  assign w_to_fire  = (r_state != ST_HUNT) && !w_consume && !w_to_stall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles since the last consumed byte while inside a frame.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_HUNT) || w_consume || w_to_fire) begin
      r_to_cnt <= '0;
    end else if (!w_to_stall) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; a sync value inside a frame is ordinary data.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_consume && (fifo_data == SYNC_BYTE)) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_consume) w_state_next = w_len_bad ? ST_HUNT : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_consume && (r_cnt == DATA_WIDTH'(1))) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_consume) w_state_next = ST_HUNT;
      end
      default: w_state_next = ST_HUNT;
    endcase
    if (w_to_fire) w_state_next = ST_HUNT;
  end

  // Pop pulse, status pulses, length counter and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_read   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err_length  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_cnt         <= '0;
      r_sum         <= '0;
    end else begin
      r_fifo_read   <= w_consume;
      r_frame_done  <= w_consume && (r_state == ST_CHECK);
      r_frame_ok    <= w_consume && (r_state == ST_CHECK) && (w_sum_add == '0);
      r_err_length  <= w_consume && (r_state == ST_LEN) && w_len_bad;
      r_err_timeout <= w_to_fire;
      if (w_consume && (r_state == ST_LEN) && !w_len_bad) begin
        r_cnt <= fifo_data;
        r_sum <= fifo_data;
      end else if (w_consume && (r_state == ST_PAYLOAD)) begin
        r_cnt <= r_cnt - 1'b1;
        r_sum <= w_sum_add;
      end
    end
  end

  // Payload stream register: load on consume, clear on handshake, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_consume && (r_state == ST_PAYLOAD)) begin
      r_out_data  <= fifo_data;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_cnt == DATA_WIDTH'(1));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign fifo_read   = r_fifo_read;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign frame_done  = r_frame_done;
  assign frame_ok    = r_frame_ok;
  assign err_length  = r_err_length;
  assign err_timeout = r_err_timeout;

endmodule
